// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, widths and rotate-priority pick for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int MAX_REQ         = 8;
  localparam int MAX_BURST_LIMIT = 16;
  // Sized for the largest legal MAX_BURST so every build shares one counter width
  localparam int BURST_W         = $clog2(MAX_BURST_LIMIT + 1);

  function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] req,
                                                   input int ptr,
                                                   input int n);
    logic [MAX_REQ-1:0] res;
    logic               hit;
    int                 idx;
    res = '0;
    hit = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !hit) begin
        idx = (ptr + k) % n;
        if (req[idx[2:0]]) begin
          res[idx[2:0]] = 1'b1;
          hit           = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr with wrap-around
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_onehot(req_ext, int'(ptr), N);
    gnt            = pick[N-1:0];
    found          = |pick;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port between producers
// Optional per-producer beat and stall counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     beat_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic               gnt_valid;
  logic               xfer;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end
  end

  assign busy       = (state_q == ARB_GRANT);
  assign grant      = grant_q;
  assign gnt_valid  = busy && req_valid[gidx_q];
  assign xfer       = gnt_valid && !fifo_full;
  assign fifo_wr_en = xfer;
  assign fifo_wdata = xfer ? req_data[int'(gidx_q)*DATA_W +: DATA_W] : '0;
  assign req_ready  = (busy && !fifo_full) ? grant_q : '0;

  // A full FIFO only stalls; release needs a paused producer or the last beat of a burst
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d     = ARB_GRANT;
          grant_d     = pick_gnt;
          gidx_d      = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (!gnt_valid || (xfer && burst_cnt_q == BURST_W'(MAX_BURST - 1))) begin
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer && beat_cnt_q[int'(gidx_q)*16 +: 16] != 16'hFFFF) begin
      beat_cnt_d[int'(gidx_q)*16 +: 16] = beat_cnt_q[int'(gidx_q)*16 +: 16] + 16'd1;
    end
    if (gnt_valid && fifo_full && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - vector table, corner sequences and randomized model check of fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wdata;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] beat_cnt;
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant      (grant),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 2 units later
  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic f);
    @(posedge clk);
    #2;
    rst       = r;
    req_valid = v;
    req_data  = d;
    fifo_full = f;
    #2;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_grant;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [7:0]  e_wdata;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model: owner index (-1 when idle), next scan start, beats taken this turn
  int m_owner, m_next, m_taken, m_stall;
  int m_beats[N];

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_next  = 0;
    m_taken = 0;
    m_stall = 0;
    for (int i = 0; i < N; i++) m_beats[i] = 0;
  endtask

  task automatic model_check(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic f);
    logic [N-1:0]  eg, er;
    logic          ew;
    logic [DW-1:0] ewd;
    eg  = '0;
    er  = '0;
    ew  = 1'b0;
    ewd = '0;
    if (m_owner >= 0) begin
      eg = N'(1) << m_owner;
      if (!f) er = eg;
      ew = bit_of(v, m_owner) && !f;
      if (ew) ewd = DW'(d >> (DW * m_owner));
    end
    check("rnd_grant", 32'(grant), 32'(eg));
    check("rnd_ready", 32'(req_ready), 32'(er));
    check("rnd_wr_en", 32'(fifo_wr_en), 32'(ew));
    check("rnd_wdata", 32'(fifo_wdata), 32'(ewd));
    check("rnd_busy", 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] v, input logic f);
    logic found;
    int   idx;
    if (r) begin
      model_reset();
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_next + k) % N;
        if (!found && bit_of(v, idx)) begin
          found   = 1'b1;
          m_owner = idx;
          m_taken = 0;
        end
      end
    end else if (!bit_of(v, m_owner)) begin
      m_next  = (m_owner + 1) % N;
      m_owner = -1;
    end else if (f) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      if (m_beats[m_owner] < 65535) m_beats[m_owner]++;
      m_taken++;
      if (m_taken == MB) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    logic [31:0]     d4;
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;
    logic            rf, rr;
    int              wr_total, exp_g, owner;

    // Producer 1 sends A5,3C then pauses; then 0 and 3 contend with rr_ptr=2
    tbl.push_back('{1'b1, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'h2, 32'h0000A500, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'h2, 32'h0000A500, 1'b0, 4'h2, 4'h2, 1'b1, 8'hA5, 1'b1});
    tbl.push_back('{1'b0, 4'h2, 32'h00003C00, 1'b0, 4'h2, 4'h2, 1'b1, 8'h3C, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h2, 4'h2, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'h9, 32'h33000011, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 4'h9, 32'h33000011, 1'b0, 4'h8, 4'h8, 1'b1, 8'h33, 1'b1});
    tbl.push_back('{1'b0, 4'h9, 32'h33000011, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 4'h9, 32'h33000011, 1'b0, 4'h1, 4'h1, 1'b1, 8'h11, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].full);
      check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].e_wr));
      check($sformatf("tbl%0d_wdata", i), 32'(fifo_wdata), 32'(tbl[i].e_wdata));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end

    // All four producers continuously valid: 4 beats then one bubble per turn
    d4 = 32'h44332211;
    drive(1'b1, 4'h0, '0, 1'b0);
    drive(1'b0, 4'hF, d4, 1'b0);
    check("all4_first_idle", 32'(grant), 32'h0);
    wr_total = 0;
    for (int c = 0; c <= 20; c++) begin
      drive(1'b0, 4'hF, d4, 1'b0);
      exp_g = (c % 5 == 4) ? 0 : (1 << ((c / 5) % 4));
      check($sformatf("all4_grant_c%0d", c), 32'(grant), 32'(exp_g));
      if (c < 20 && fifo_wr_en) begin
        wr_total++;
        check($sformatf("all4_wdata_c%0d", c), 32'(fifo_wdata), 32'h11 * 32'((c / 5) + 1));
      end
    end
    check("all4_writes_in_20", 32'(wr_total), 32'd16);

    // Full for 3 cycles after two beats of producer 0
    drive(1'b1, 4'h0, '0, 1'b0);
    drive(1'b0, 4'h1, d4, 1'b0);
    drive(1'b0, 4'h1, d4, 1'b0);
    check("stall_beat1", 32'(fifo_wr_en), 32'd1);
    drive(1'b0, 4'h1, d4, 1'b0);
    check("stall_beat2", 32'(fifo_wr_en), 32'd1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'h1, d4, 1'b1);
      check($sformatf("stall_wr_c%0d", c), 32'(fifo_wr_en), 32'd0);
      check($sformatf("stall_ready_c%0d", c), 32'(req_ready), 32'd0);
      check($sformatf("stall_grant_c%0d", c), 32'(grant), 32'h1);
    end
    drive(1'b0, 4'h1, d4, 1'b0);
    check("stall_beat3", 32'(fifo_wr_en), 32'd1);
    drive(1'b0, 4'h1, d4, 1'b0);
    check("stall_beat4", 32'(fifo_wr_en), 32'd1);
    drive(1'b0, 4'h1, d4, 1'b0);
    check("stall_release_bubble", 32'(grant), 32'h0);
    drive(1'b0, 4'h1, d4, 1'b0);
    check("single_regrant", 32'(grant), 32'h1);

    // Reset mid-burst of producer 2 with rr_ptr left at 2
    drive(1'b1, 4'h0, '0, 1'b0);
    drive(1'b0, 4'h2, d4, 1'b0);
    drive(1'b0, 4'h0, d4, 1'b0);
    check("rst_p1_paused", 32'(fifo_wr_en), 32'd0);
    drive(1'b0, 4'h4, d4, 1'b0);
    drive(1'b0, 4'h4, d4, 1'b0);
    check("rst_p2_granted", 32'(grant), 32'h4);
    drive(1'b0, 4'h4, d4, 1'b0);
    check("rst_p2_beat2", 32'(fifo_wr_en), 32'd1);
    drive(1'b1, 4'h4, d4, 1'b0);
    drive(1'b0, 4'h0, d4, 1'b0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    drive(1'b0, 4'h6, d4, 1'b0);
    drive(1'b0, 4'h6, d4, 1'b0);
    check("rst_scan_from0", 32'(grant), 32'h2);

    // Randomized traffic against the model
    drive(1'b1, 4'h0, '0, 1'b0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 199) == 0);
      rv = N'($urandom_range(0, 15));
      rd = $urandom;
      rf = ($urandom_range(0, 3) == 0);
      drive(rr, rv, rd, rf);
      model_check(rv, rd, rf);
      model_step(rr, rv, rf);
    end

`ifdef FIFO_WR_ARB_STATS_EN
    drive(1'b0, 4'h0, '0, 1'b0);
    for (int i = 0; i < N; i++)
      check($sformatf("rnd_beat_cnt%0d", i), 32'(beat_cnt[i*16 +: 16]), 32'(m_beats[i]));
    check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));

    drive(1'b1, 4'h0, '0, 1'b0);
    wr_total = 0;
    owner    = 0;
    while (wr_total < 65540 && owner < 90000) begin
      drive(1'b0, 4'h4, d4, 1'b0);
      if (fifo_wr_en) wr_total++;
      owner++;
    end
    check("sat_budget", 32'(wr_total >= 65540), 32'd1);
    drive(1'b0, 4'h0, '0, 1'b0);
    check("sat_p2", 32'(beat_cnt[2*16 +: 16]), 32'hFFFF);
    check("sat_p0", 32'(beat_cnt[0 +: 16]), 32'h0);
    check("sat_p1", 32'(beat_cnt[16 +: 16]), 32'h0);
    check("sat_p3", 32'(beat_cnt[48 +: 16]), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
